imu_packet_parser: RTL and testbench
====================================

Name: imu_packet_parser

Overview:
- Downstream consumer of the Arduino SPI slave receive stage.
- Watches the raw chip-select, waits for the slave's synchronized 16-byte snapshot to settle, then walks the snapshot byte-serially.
- Validates the header (and optionally a checksum) and commits decoded Euler angles and gyro rates to holding registers with a one-cycle valid strobe.
- Also maintains good/drop counters and a staleness flag for the MCU-facing logic.

Parameters:
SETTLE_CYCLES, 4, clk cycles waited after detected CS rising edge before scanning (covers upstream 3-cycle CDC path)
TIMEOUT_CYCLES, 2000000, clk cycles without a good packet before stale asserts
CNT_W, 16, width of good/drop counters

Ports:
clk  input  1  FPGA system clock
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  raw SPI chip select from Arduino (asynchronous), same net as the slave's cs_n
packet_buffer  input  8 x [0:15]  synchronized packet bytes from the SPI slave; byte 0 = header
roll  output  16  signed, 0.01 deg/LSB
pitch  output  16  signed, 0.01 deg/LSB
yaw  output  16  signed, 0.01 deg/LSB
gyro_x  output  16  signed, scaled by 2000
gyro_y  output  16  signed
gyro_z  output  16  signed
flags  output  8  flag byte of last good packet
sample_valid  output  1  one-cycle pulse when outputs update
busy  output  1  high in any state other than IDLE
stale  output  1  no good packet within TIMEOUT_CYCLES
good_count  output  CNT_W  saturating count of committed packets
drop_count  output  CNT_W  saturating count of rejected packets

Behaviour:
- Reset (rst_n low, async): all data outputs 0; sample_valid 0; busy 0; stale 1; counters 0; FSM IDLE; timeout counter 0.
- CS path:
  - cs_n passes through a 2-flop synchronizer plus a previous-value flop.
  - cs_rise is high when the previous value is 0 and the synchronized value is 1.
  - The cycle where cs_rise is first high is cycle E.
- FSM states: IDLE, SETTLE, SCAN, COMMIT.
  - IDLE: on cs_rise -> SETTLE, load settle counter 0.
  - SETTLE: counts SETTLE_CYCLES cycles, then -> SCAN with byte index 0 and xor accumulator 0.
  - SCAN: each cycle, packet_buffer[idx] is latched into a staging byte and XORed into the accumulator. hdr_ok is set at idx 0 if the byte equals 0xAA. After idx 15 -> COMMIT.
  - COMMIT (1 cycle): if the packet is valid, copy staging to outputs, pulse sample_valid, increment good_count. Otherwise increment drop_count. Either way -> IDLE.
- Latency: sample_valid is high exactly SETTLE_CYCLES+18 cycles after E (default 22).
- Byte map (MSB first): roll={b1,b2}, pitch={b3,b4}, yaw={b5,b6}, gyro_x={b7,b8}, gyro_y={b9,b10}, gyro_z={b11,b12}, flags=b13, b14/b15 reserved.
- Output holding: outputs hold their values between commits; rejected packets never alter them.
- Valid packet: hdr_ok, plus the checksum term when the feature is enabled.
- Counters saturate at all-ones; there is no wrap.
- Staleness:
  - Timeout counter increments every cycle, saturating at TIMEOUT_CYCLES.
  - It clears to 0 in the cycle of a good commit.
  - stale = (timeout counter == TIMEOUT_CYCLES) OR (good_count == 0).
- cs_rise during SETTLE or SCAN: abort the current scan and restart SETTLE from 0. No counter change, no output change.
- cs_rise during COMMIT: the commit completes, then the FSM goes to SETTLE instead of IDLE.
- Reset mid-scan: immediate return to reset values; partial staging data is discarded.
- busy is a registered decode of state != IDLE.

Optional Feature:
- Macro: IMU_PKT_CHECKSUM_EN.
- Defined: b15 is an XOR checksum. A packet is valid only if hdr_ok and the XOR of b0..b14 equals b15. Otherwise it counts as a drop.
- Undefined: b14/b15 are ignored, validity is hdr_ok only, and the XOR logic is not synthesized.

Test Plan:
- Packet AA 01 2C FF 38 00 00 00 10 FF F0 00 00 05 00 xx, then raise cs_n -> 22 cycles after detected edge: sample_valid=1 for 1 cycle; roll=0x012C (300), pitch=0xFF38 (-200), yaw=0, gyro_x=0x0010, gyro_y=0xFFF0, gyro_z=0, flags=0x05; good_count=1; stale=0.
- Header 0x55 with otherwise valid bytes -> no sample_valid; drop_count=1; outputs keep prior values.
- With IMU_PKT_CHECKSUM_EN defined:
  - Valid packet with b15 = XOR(b0..b14) -> commit.
  - Same packet with b15 flipped -> drop_count increments.
  - Without the macro, both packets commit.
- Second cs_rise 5 cycles into SCAN -> no commit from the first packet; exactly one sample_valid, SETTLE_CYCLES+18 cycles after the second edge.
- With TIMEOUT_CYCLES=100: one good packet, then idle -> stale=0 until 100 cycles after the commit, then stale=1; the next good packet clears it.
- Assert rst_n=0 mid-SCAN, then release -> all outputs 0, stale=1, busy=0, counters 0; a following valid packet commits normally.

Source files
------------

// File: rtl/imu_packet_parser.sv
// imu_packet_parser: walks the SPI slave's 16-byte snapshot after CS rises, validates it and commits IMU samples.
// Optional checksum validation on byte 15 is enabled by defining IMU_PKT_CHECKSUM_EN.
module imu_packet_parser #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs_n,
    input  logic [7:0]              packet_buffer [0:15],
    output logic signed [15:0]      roll,
    output logic signed [15:0]      pitch,
    output logic signed [15:0]      yaw,
    output logic signed [15:0]      gyro_x,
    output logic signed [15:0]      gyro_y,
    output logic signed [15:0]      gyro_z,
    output logic [7:0]              flags,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    stale,
    output logic [CNT_W-1:0]        good_count,
    output logic [CNT_W-1:0]        drop_count
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SCAN, COMMIT} state_t;

    state_t        state;
    logic [SW-1:0] scnt;
    logic [3:0]    idx;
    logic          hdr_ok;
    logic [7:0]    stage [1:13];
    logic [TW-1:0] tcnt;
    logic          cs_meta, cs_sync, cs_prev;
    logic          cs_rise;
    logic          pkt_ok;
    logic [7:0]    cur;

    assign cur     = packet_buffer[idx];
    assign cs_rise = cs_sync & ~cs_prev;
    assign stale   = (tcnt == TW'(TIMEOUT_CYCLES)) || (good_count == '0);

`ifdef IMU_PKT_CHECKSUM_EN
    logic [7:0] acc;
    // Running XOR of every scanned byte; zero after byte 15 means the checksum matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= 8'h00;
        else if (state == SETTLE) acc <= 8'h00;
        else if (state == SCAN) acc <= acc ^ cur;
    end
    assign pkt_ok = hdr_ok && (acc == 8'h00);
`else
    assign pkt_ok = hdr_ok;
`endif

    // Synchronize the raw chip select and keep its previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_meta <= cs_n;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    // Parser FSM: settle, scan the snapshot byte-serially, then commit or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            scnt         <= '0;
            idx          <= '0;
            hdr_ok       <= 1'b0;
            for (int i = 1; i <= 13; i++) stage[i] <= 8'h00;
            roll         <= '0;
            pitch        <= '0;
            yaw          <= '0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
            flags        <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            good_count   <= '0;
            drop_count   <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_rise) begin
                        state <= SETTLE;
                        scnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cs_rise) begin
                        scnt <= '0;
                    end else if (scnt == SW'(SETTLE_CYCLES - 1)) begin
                        state  <= SCAN;
                        idx    <= '0;
                        hdr_ok <= 1'b0;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (cs_rise) begin
                        state <= SETTLE;
                        scnt  <= '0;
                    end else begin
                        if (idx == 4'd0) hdr_ok <= (cur == 8'hAA);
                        if (idx >= 4'd1 && idx <= 4'd13) stage[idx] <= cur;
                        idx <= idx + 1'b1;
                        if (idx == 4'd15) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (pkt_ok) begin
                        roll         <= {stage[1], stage[2]};
                        pitch        <= {stage[3], stage[4]};
                        yaw          <= {stage[5], stage[6]};
                        gyro_x       <= {stage[7], stage[8]};
                        gyro_y       <= {stage[9], stage[10]};
                        gyro_z       <= {stage[11], stage[12]};
                        flags        <= stage[13];
                        sample_valid <= 1'b1;
                        if (good_count != '1) good_count <= good_count + 1'b1;
                    end else if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                    state <= cs_rise ? SETTLE : IDLE;
                    scnt  <= '0;
                    busy  <= cs_rise;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Cycles since the last good commit, saturating at the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else if (state == COMMIT && pkt_ok) tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
    end
endmodule

// File: tb/tb_imu_packet_parser.sv
// tb_imu_packet_parser: directed checks of packet commit, drop, abort, staleness and reset.
module tb_imu_packet_parser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n = 1'b1;
    logic [7:0] pkt [0:15];
    logic signed [15:0] roll, pitch, yaw, gyro_x, gyro_y, gyro_z;
    logic [7:0] flags;
    logic sample_valid, busy, stale;
    logic [15:0] good_count, drop_count;

    int checks = 0;
    int fails = 0;
    int exp_good = 0;
    int exp_drop = 0;
    int lat, pulses;

    // Cycles from the cs_n raise to the pulse: 2 synchronizer stages, 4 settle, 18 scan/commit.
    localparam int LAT = 2 + 4 + 18;

    imu_packet_parser #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .packet_buffer(pkt),
        .roll(roll), .pitch(pitch), .yaw(yaw), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .flags(flags), .sample_valid(sample_valid), .busy(busy), .stale(stale),
        .good_count(good_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Packet A from the test plan; b15 = XOR(b0..b14) = 0x5A.
    task automatic load_base();
        logic [7:0] a [0:15];
        a = '{8'hAA, 8'h01, 8'h2C, 8'hFF, 8'h38, 8'h00, 8'h00, 8'h00,
              8'h10, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h5A};
        for (int i = 0; i < 16; i++) pkt[i] = a[i];
    endtask

    // Frame the current buffer with a CS low/high and watch 40 cycles for pulses.
    task automatic send(output int l, output int p);
        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        l = -1;
        p = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sample_valid) begin
                p++;
                if (l < 0) l = k;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stale !== 1'b1) begin fails++; $display("FAIL reset_stale: got %b want 1", stale); end
        checks++; if ({roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags} !== 104'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags}); end
        checks++; if ({good_count, drop_count} !== 32'h0) begin fails++; $display("FAIL reset_counts: got %h want 0", {good_count, drop_count}); end
    endtask

    task automatic test_basic();
        load_base();
        send(lat, pulses);
        exp_good++;
        checks++; if (lat != LAT) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++; if (pulses != 1) begin fails++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
        checks++; if (roll !== 16'h012C) begin fails++; $display("FAIL basic_roll: got %h want 012c", roll); end
        checks++; if (pitch !== 16'hFF38) begin fails++; $display("FAIL basic_pitch: got %h want ff38", pitch); end
        checks++; if (yaw !== 16'h0000) begin fails++; $display("FAIL basic_yaw: got %h want 0000", yaw); end
        checks++; if (gyro_x !== 16'h0010) begin fails++; $display("FAIL basic_gx: got %h want 0010", gyro_x); end
        checks++; if (gyro_y !== 16'hFFF0) begin fails++; $display("FAIL basic_gy: got %h want fff0", gyro_y); end
        checks++; if (gyro_z !== 16'h0000) begin fails++; $display("FAIL basic_gz: got %h want 0000", gyro_z); end
        checks++; if (flags !== 8'h05) begin fails++; $display("FAIL basic_flags: got %h want 05", flags); end
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL basic_good: got %0d want %0d", good_count, exp_good); end
        checks++; if (stale !== 1'b0) begin fails++; $display("FAIL basic_stale: got %b want 0", stale); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_bad_header();
        load_base();
        pkt[0] = 8'h55;
        pkt[1] = 8'h7F;
        send(lat, pulses);
        exp_drop++;
        checks++; if (pulses != 0) begin fails++; $display("FAIL hdr_pulses: got %0d want 0", pulses); end
        checks++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL hdr_drop: got %0d want %0d", drop_count, exp_drop); end
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL hdr_good: got %0d want %0d", good_count, exp_good); end
        checks++; if (roll !== 16'h012C) begin fails++; $display("FAIL hdr_roll_held: got %h want 012c", roll); end
    endtask

    task automatic test_checksum();
        load_base();
        pkt[1] = 8'h02;
        pkt[15] = 8'h59;
        send(lat, pulses);
        exp_good++;
        checks++; if (pulses != 1) begin fails++; $display("FAIL csum_ok_pulses: got %0d want 1", pulses); end
        checks++; if (roll !== 16'h022C) begin fails++; $display("FAIL csum_ok_roll: got %h want 022c", roll); end
        pkt[1] = 8'h03;
        pkt[15] = 8'hA7;
        send(lat, pulses);
`ifdef IMU_PKT_CHECKSUM_EN
        exp_drop++;
        checks++; if (pulses != 0) begin fails++; $display("FAIL csum_bad_pulses: got %0d want 0", pulses); end
        checks++; if (roll !== 16'h022C) begin fails++; $display("FAIL csum_bad_roll: got %h want 022c", roll); end
`else
        exp_good++;
        checks++; if (pulses != 1) begin fails++; $display("FAIL csum_bad_pulses: got %0d want 1", pulses); end
        checks++; if (roll !== 16'h032C) begin fails++; $display("FAIL csum_bad_roll: got %h want 032c", roll); end
`endif
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL csum_good: got %0d want %0d", good_count, exp_good); end
        checks++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL csum_drop: got %0d want %0d", drop_count, exp_drop); end
    endtask

    // Second CS edge lands 10 cycles after the first, i.e. 5 bytes into the scan.
    task automatic test_abort();
        load_base();
        pkt[1] = 8'h04;
        pkt[15] = 8'h5F;
        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (sample_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 8) cs_n = 1'b0;
            if (k == 10) cs_n = 1'b1;
        end
        exp_good++;
        checks++; if (pulses != 1) begin fails++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
        checks++; if (lat != 10 + LAT) begin fails++; $display("FAIL abort_latency: got %0d want %0d", lat, 10 + LAT); end
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL abort_good: got %0d want %0d", good_count, exp_good); end
        checks++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL abort_drop: got %0d want %0d", drop_count, exp_drop); end
        checks++; if (roll !== 16'h042C) begin fails++; $display("FAIL abort_roll: got %h want 042c", roll); end
    endtask

    task automatic test_stale();
        load_base();
        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        for (int k = 1; k <= LAT + 100; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                checks++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL stale_commit: got %b want 1", sample_valid); end
                checks++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_at_commit: got %b want 0", stale); end
            end
            if (k == LAT + 99) begin
                checks++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_early: got %b want 0", stale); end
            end
            if (k == LAT + 100) begin
                checks++; if (stale !== 1'b1) begin fails++; $display("FAIL stale_timeout: got %b want 1", stale); end
            end
        end
        exp_good++;
        send(lat, pulses);
        exp_good++;
        checks++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_cleared: got %b want 0", stale); end
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL stale_good: got %0d want %0d", good_count, exp_good); end
    endtask

    task automatic test_reset_mid_scan();
        load_base();
        @(negedge clk) cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        exp_good = 0;
        exp_drop = 0;
        checks++; if ({roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags} !== 104'h0) begin fails++; $display("FAIL midrst_data: got %h want 0", {roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags}); end
        checks++; if ({good_count, drop_count} !== 32'h0) begin fails++; $display("FAIL midrst_counts: got %h want 0", {good_count, drop_count}); end
        checks++; if ({stale, busy, sample_valid} !== 3'b100) begin fails++; $display("FAIL midrst_status: got %b want 100", {stale, busy, sample_valid}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(lat, pulses);
        exp_good++;
        checks++; if (lat != LAT || pulses != 1) begin fails++; $display("FAIL midrst_commit: got lat %0d pulses %0d want %0d/1", lat, pulses, LAT); end
        checks++; if (good_count !== 16'(exp_good)) begin fails++; $display("FAIL midrst_good: got %0d want %0d", good_count, exp_good); end
        checks++; if (roll !== 16'h012C) begin fails++; $display("FAIL midrst_roll: got %h want 012c", roll); end
    endtask

    initial begin
        load_base();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_basic();
        test_bad_header();
        test_checksum();
        test_abort();
        test_stale();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
